// File: rtl/cache_mem_arbiter.sv
// Shares one cacheline-wide memory port between icache fills and dcache fills/writebacks.
// One transaction at a time; every output comes straight from a register.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_e;

  state_e            state_q;
  logic              last_grant_d_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              i_resp_q;
  logic              d_resp_q;

  logic i_req;
  logic d_req;
  logic grant_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Contention goes to whichever side did not win last time, or always to the dcache.
  always_comb begin
    grant_d = 1'b0;
    if (d_req && !i_req) begin
      grant_d = 1'b1;
    end else if (d_req && i_req) begin
      grant_d = RR_EN ? !last_grant_d_q : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      last_grant_d_q <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_address_q  <= '0;
      mem_wdata_q    <= '0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            if (grant_d) begin
              state_q        <= D_BUSY;
              last_grant_d_q <= 1'b1;
              mem_address_q  <= d_address;
              // A simultaneous read+write is serviced as the writeback.
              mem_write_q    <= d_write;
              mem_read_q     <= !d_write;
              if (d_write) begin
                mem_wdata_q <= d_wdata;
              end
            end else begin
              state_q        <= I_BUSY;
              last_grant_d_q <= 1'b0;
              mem_address_q  <= i_address;
              mem_read_q     <= 1'b1;
              mem_write_q    <= 1'b0;
            end
          end
        end
        I_BUSY: begin
          if (mem_resp) begin
            mem_read_q <= 1'b0;
            i_rdata_q  <= mem_rdata;
            i_resp_q   <= 1'b1;
            state_q    <= DONE;
          end
        end
        D_BUSY: begin
          if (mem_resp) begin
            if (mem_read_q) begin
              d_rdata_q <= mem_rdata;
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            d_resp_q    <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          // Extra cycle lets the requester drop its request before IDLE samples again.
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_rdata     = i_rdata_q;
  assign i_resp      = i_resp_q;
  assign d_rdata     = d_rdata_q;
  assign d_resp      = d_resp_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

  always @(posedge clk) begin
    assert (!(d_read && d_write))
      else $warning("cache_mem_arbiter: d_read and d_write both high, serviced as a writeback");
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench: table vectors, hand sequences for contention/reset corners,
// and randomized traffic checked against a transaction-level model of the arbiter.
module tb_cache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_read, d_read, d_write, mem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, mem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_resp, d_resp, mem_read, mem_write;
  logic [AW-1:0] mem_address;

  logic          b_i_read, b_d_read, b_d_write, b_mem_resp;
  logic [AW-1:0] b_i_address, b_d_address;
  logic [LW-1:0] b_d_wdata, b_mem_rdata;
  logic [LW-1:0] b_i_rdata, b_d_rdata, b_mem_wdata;
  logic          b_i_resp, b_d_resp, b_mem_read, b_mem_write;
  logic [AW-1:0] b_mem_address;

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .i_read(b_i_read), .i_address(b_i_address), .i_rdata(b_i_rdata), .i_resp(b_i_resp),
    .d_read(b_d_read), .d_write(b_d_write), .d_address(b_d_address), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_resp(b_d_resp),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_address(b_mem_address),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            dside;
    bit            wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            lat;
  } txn_t;

  typedef struct {
    bit            i_rd;
    bit            d_rd;
    bit            d_wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            lat;
    bit            exp_wr;
    bit            exp_d;
  } vec_t;

  // Model state: who won the most recent grant, and what each rdata port should hold.
  bit            exp_last_d;
  logic [LW-1:0] exp_irdata;
  logic [LW-1:0] exp_drdata;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] r;
    r = $urandom();
    r[4:0] = '0;
    return r;
  endfunction

  function automatic bit pick_d(input bit i_pend, input bit d_pend);
    if (!i_pend) return 1'b1;
    if (!d_pend) return 1'b0;
    return !exp_last_d;
  endfunction

  task automatic drive_txn(input txn_t t);
    if (t.dside) begin
      d_read = !t.wr; d_write = t.wr; d_address = t.addr; d_wdata = t.wdata;
    end else begin
      i_read = 1'b1; i_address = t.addr;
    end
  endtask

  // Waits for the grant, holds memory busy for t.lat cycles, responds, and checks the pulse.
  task automatic serve(input txn_t t, input bit keep);
    int waited = 0;
    bit seen = 1'b0;
    while (!seen && waited < 8) begin
      @(negedge clk);
      waited++;
      seen = mem_read | mem_write;
    end
    check("grant_latency", LW'(waited), LW'(1));
    if (!seen) return;
    exp_last_d = t.dside;
    check("strobes", LW'({mem_read, mem_write}), LW'({!t.wr, t.wr}));
    check("mem_address", LW'(mem_address), LW'(t.addr));
    if (t.wr) check("mem_wdata", mem_wdata, t.wdata);
    for (int k = 0; k < t.lat; k++) begin
      @(negedge clk);
      check("busy_hold", LW'({i_resp, d_resp, mem_read, mem_write, mem_address}),
            LW'({2'b00, !t.wr, t.wr, t.addr}));
      if (t.wr) check("wdata_hold", mem_wdata, t.wdata);
    end
    mem_rdata = t.rdata;
    mem_resp  = 1'b1;
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = rand_line();
    if (!t.dside) exp_irdata = t.rdata;
    else if (!t.wr) exp_drdata = t.rdata;
    check("resp_side", LW'({i_resp, d_resp}), LW'(t.dside ? 2'b01 : 2'b10));
    check("strobe_drop", LW'({mem_read, mem_write}), LW'(2'b00));
    check("i_rdata", i_rdata, exp_irdata);
    check("d_rdata", d_rdata, exp_drdata);
    @(negedge clk);
    check("resp_once", LW'({i_resp, d_resp}), LW'(2'b00));
    check("i_rdata_hold", i_rdata, exp_irdata);
    check("d_rdata_hold", d_rdata, exp_drdata);
    if (!keep) begin
      if (t.dside) begin d_read = 1'b0; d_write = 1'b0; end
      else i_read = 1'b0;
    end
  endtask

  task automatic serve_b(input logic [AW-1:0] exp_addr, input bit exp_d);
    int waited = 0;
    bit seen = 1'b0;
    logic [LW-1:0] line;
    while (!seen && waited < 8) begin
      @(negedge clk);
      waited++;
      seen = b_mem_read;
    end
    check("fp_grant_latency", LW'(waited), LW'(1));
    check("fp_grant_addr", LW'(b_mem_address), LW'(exp_addr));
    line = rand_line();
    b_mem_rdata = line;
    b_mem_resp  = 1'b1;
    @(negedge clk);
    b_mem_resp = 1'b0;
    check("fp_resp_side", LW'({b_i_resp, b_d_resp}), LW'(exp_d ? 2'b01 : 2'b10));
    check("fp_rdata", exp_d ? b_d_rdata : b_i_rdata, line);
    @(negedge clk);
  endtask

  task automatic reset_model();
    exp_last_d = 1'b0;
    exp_irdata = '0;
    exp_drdata = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    txn_t t, ti, td;
    logic [LW-1:0] aa_line, w1234;

    aa_line = {32{8'hAA}};
    w1234   = {16{16'h1234}};
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, '0, aa_line, 5, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0100, w1234, {32{8'hEE}}, 3, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_2000, '0, {32{8'h55}}, 0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFC0, '0, {8{32'h0BAD_F00D}}, 1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'hDEAD_BEE0, {8{32'hCAFE_0001}}, '0, 7, 1'b1, 1'b1};

    rst = 1'b0;
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    b_i_read = 0; b_d_read = 0; b_d_write = 0; b_mem_resp = 0;
    b_i_address = '0; b_d_address = '0; b_d_wdata = '0; b_mem_rdata = '0;
    reset_model();
    repeat (3) @(negedge clk);
    check("reset_ctrl", LW'({i_resp, d_resp, mem_read, mem_write, mem_address}), '0);
    check("reset_data", i_rdata | d_rdata | mem_wdata, '0);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      t = '{vecs[v].exp_d, vecs[v].exp_wr, vecs[v].addr, vecs[v].wdata, vecs[v].rdata, vecs[v].lat};
      i_read = vecs[v].i_rd; i_address = vecs[v].addr;
      d_read = vecs[v].d_rd; d_write = vecs[v].d_wr;
      d_address = vecs[v].addr; d_wdata = vecs[v].wdata;
      serve(t, 1'b0);
    end

    // Contention straight out of reset, requests re-asserted for four rounds.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    reset_model();
    @(negedge clk);
    ti = '{1'b0, 1'b0, 32'h0000_0A40, '0, rand_line(), 2};
    td = '{1'b1, 1'b0, 32'h0000_0B80, '0, rand_line(), 2};
    drive_txn(ti);
    drive_txn(td);
    for (int r = 0; r < 4; r++) begin
      if (pick_d(1'b1, 1'b1)) serve(td, 1'b1);
      else serve(ti, 1'b1);
      td.rdata = rand_line();
      ti.rdata = rand_line();
    end
    i_read = 0; d_read = 0;
    @(negedge clk);
    @(negedge clk);
    check("idle_after_drop", LW'({mem_read, mem_write}), LW'(2'b00));

    // Reset two cycles into a dcache writeback.
    t = '{1'b1, 1'b1, 32'h0000_0300, rand_line(), '0, 0};
    drive_txn(t);
    @(negedge clk);
    check("pre_reset_write", LW'({mem_read, mem_write}), LW'(2'b01));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_reset_ctrl", LW'({i_resp, d_resp, mem_read, mem_write, mem_address}), '0);
    check("async_reset_data", i_rdata | d_rdata | mem_wdata, '0);
    d_read = 0; d_write = 0;
    reset_model();
    @(negedge clk);
    rst = 1'b1;
    t = '{1'b0, 1'b0, 32'h0000_0480, '0, rand_line(), 2};
    drive_txn(t);
    serve(t, 1'b0);

    // Stray memory response while idle, then a dual read+write request.
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    check("spurious_resp", LW'({i_resp, d_resp, mem_read, mem_write}), '0);
    @(negedge clk);
    check("spurious_resp2", LW'({i_resp, d_resp, mem_read, mem_write}), '0);
    t = '{1'b1, 1'b1, 32'h0000_05A0, rand_line(), rand_line(), 1};
    d_read = 1'b1; d_write = 1'b1; d_address = t.addr; d_wdata = t.wdata;
    serve(t, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      ti = '{1'b0, 1'b0, rand_addr(), '0, rand_line(), $urandom_range(0, 6)};
      td = '{1'b1, 1'($urandom_range(0, 1)), rand_addr(), rand_line(), rand_line(), $urandom_range(0, 6)};
      if (kind == 0) begin
        drive_txn(ti);
        serve(ti, 1'b0);
      end else if (kind == 1) begin
        drive_txn(td);
        serve(td, 1'b0);
      end else begin
        drive_txn(ti);
        drive_txn(td);
        if (pick_d(1'b1, 1'b1)) begin
          serve(td, 1'b0);
          serve(ti, 1'b0);
        end else begin
          serve(ti, 1'b0);
          serve(td, 1'b0);
        end
      end
    end

    // Fixed dcache priority: the icache waits until the dcache stops asking.
    b_i_read = 1'b1; b_i_address = 32'h0000_0A00;
    b_d_read = 1'b1; b_d_address = 32'h0000_0B00;
    for (int r = 0; r < 4; r++) begin
      serve_b(32'h0000_0B00, 1'b1);
    end
    b_d_read = 1'b0;
    serve_b(32'h0000_0A00, 1'b0);
    b_i_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("fp_idle", LW'({b_mem_read, b_mem_write, b_i_resp, b_d_resp}), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single cacheline-wide physical memory port between the icache and the dcache of the pipelined RV32I core.
- Accepts line-fill requests from both caches, and line-writeback requests from the dcache.
- Grants one request at a time and drives the memory port from registered copies of that request.
- Returns the memory response only to the granted cache.

Parameters:
ADDR_W, 32, byte address width of cache and memory requests
LINE_W, 256, cacheline width in bits
RR_EN, 1, 1 = round-robin on simultaneous requests; 0 = fixed dcache priority

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
i_read  in  1  icache line-fill request; held until i_resp
i_address  in  ADDR_W  icache line address
i_rdata  out  LINE_W  line returned to icache; valid while i_resp=1
i_resp  out  1  one-cycle completion pulse to icache
d_read  in  1  dcache line-fill request; held until d_resp
d_write  in  1  dcache writeback request; held until d_resp
d_address  in  ADDR_W  dcache line address
d_wdata  in  LINE_W  writeback data
d_rdata  out  LINE_W  line returned to dcache; valid while d_resp=1
d_resp  out  1  one-cycle completion pulse to dcache
mem_read  out  1  memory read strobe, held for the whole transaction
mem_write  out  1  memory write strobe, held for the whole transaction
mem_address  out  ADDR_W  registered transaction address
mem_wdata  out  LINE_W  registered writeback data
mem_rdata  in  LINE_W  memory read data; valid with mem_resp
mem_resp  in  1  memory completion pulse

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, state=IDLE, last_grant=ICACHE. Any transaction in flight is abandoned and mem_read/mem_write drop immediately. After reset deasserts, memory is assumed idle.
- States: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE:
  - No request pending: stay in IDLE.
  - Only icache pending: go to I_BUSY.
  - Only dcache pending (d_read or d_write): go to D_BUSY.
  - Both pending, RR_EN=1: grant the requester that is not last_grant. RR_EN=0: grant the dcache.
  - On grant edge: register mem_address and mem_wdata (dcache write only), assert mem_read or mem_write, update last_grant.
- Grant latency: a request sampled in IDLE at edge N produces strobes visible from edge N+1.
- I_BUSY / D_BUSY:
  - mem_read/mem_write, mem_address and mem_wdata are held stable.
  - Requester inputs are ignored (no re-sampling).
  - On mem_resp=1: deassert strobes, capture mem_rdata into the granted side's rdata register, pulse that side's resp, and go to DONE.
  - For a dcache write, d_rdata is not updated.
- DONE: resp is high for exactly this one cycle, then return to IDLE. Requesters drop their requests in the cycle after resp. The extra cycle prevents a stale re-grant.
- Response latency: mem_resp at edge M gives resp=1 from M+1 to M+2. The next grant can occur at edge M+2 at the earliest.
- i_rdata/d_rdata hold their last captured value outside resp.
- d_read and d_write both high: treat as a write. A simulation-only assertion flags it.
- Requester drops its request mid-transaction: the memory transaction completes anyway and resp still pulses.
- mem_resp while in IDLE or DONE: ignored, no resp generated.
- mem_read and mem_write are never high together, and never high in IDLE or DONE.
- No combinational path from any input to any output.

Test Plan:
1. Icache only: i_read=1, i_address=0x0000_0040. Memory returns 0xAA..AA after 5 cycles.
   -> mem_read=1 with mem_address=0x40 one cycle after request. i_resp pulses exactly once with i_rdata=0xAA..AA. d_resp stays 0.
2. Dcache writeback: d_write=1, d_address=0x100, d_wdata=0x1234..
   -> mem_write=1, mem_wdata=0x1234.. held stable until mem_resp. d_resp pulses once. d_rdata unchanged.
3. Simultaneous i_read and d_read out of reset, RR_EN=1.
   -> dcache granted first. Icache granted at the IDLE cycle following DONE. Each resp pulses once, to the correct side.
4. Repeated contention: both requests re-asserted immediately after each response, 4 rounds.
   -> grants alternate D,I,D,I. With RR_EN=0: D,D,D,D, and the icache starves until the dcache idles.
5. Reset mid-transaction: rst=0 two cycles into D_BUSY.
   -> mem_write and all outputs 0 immediately. After release, a new i_read is serviced normally with mem_address taken from the new request.
6. Spurious mem_resp in IDLE, plus d_read=d_write=1.
   -> spurious mem_resp produces no resp. The dual request issues mem_write only and fires the assertion.
